fetch_stage: RTL and testbench

- Front-end F1 stage that sits directly upstream of the decoder.
- Generates sequential PCs and issues 32-bit instruction fetches to an in-order instruction memory port.
- Buffers the returned instructions in a small queue and presents them as f1_valid_o/f1_pc_o/f1_inst_o.
- Honours the decoder's stall and the back-end redirect/flush.

---
 rtl/fetch_stage.sv | 147 ++++++++++++++
 tb/tb_fetch_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// F1 fetch stage: sequential PC generation, in-order instruction memory
// requests, a small circular fetch queue feeding the decoder, and flush /
// redirect handling that discards responses to requests made before the flush.
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid_i,
  input  logic [63:0] redirect_pc_i,
  input  logic        stall_f1_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [63:0] imem_req_addr_o,
  input  logic        imem_resp_valid_i,
  input  logic [31:0] imem_resp_inst_i,
  output logic        f1_valid_o,
  output logic [63:0] f1_pc_o,
  output logic [31:0] f1_inst_o
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam logic [CNT_W:0] QD_EXT = (CNT_W + 1)'(QDEPTH);

  // Control state
  logic [63:0]       pc_q, pc_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PTR_W-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]  count_q, count_d;
  // pend: allocated entries still waiting for their instruction
  logic [CNT_W-1:0]  pend_q, pend_d;
  // drop: responses still owed to requests issued before a redirect
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic              started_q, started_d;
  logic [QDEPTH-1:0] filled_q, filled_d;

  // Queue payload (not reset: only visible through count/filled gating)
  logic [63:0] epc_q   [QDEPTH];
  logic [63:0] epc_d   [QDEPTH];
  logic [31:0] einst_q [QDEPTH];
  logic [31:0] einst_d [QDEPTH];

  logic [CNT_W:0] occ;
  logic [CNT_W:0] outstanding;
  logic           push;
  logic           resp_any;
  logic           resp_fill;
  logic           pop;
  logic           q_nonempty;

  // Request/response handshakes and decoder-facing outputs
  always_comb begin
    occ              = {1'b0, count_q} + {1'b0, drop_q};
    outstanding      = {1'b0, pend_q} + {1'b0, drop_q};
    imem_req_valid_o = started_q & ~redirect_valid_i & (occ < QD_EXT);
    imem_req_addr_o  = pc_q;
    push             = imem_req_valid_o & imem_req_ready_i;
    resp_any         = imem_resp_valid_i & (outstanding != '0);
    resp_fill        = resp_any & (drop_q == '0);
    q_nonempty       = (count_q != '0);
    f1_valid_o       = q_nonempty & filled_q[head_q] & ~redirect_valid_i;
    f1_pc_o          = q_nonempty ? epc_q[head_q] : 64'h0;
    f1_inst_o        = q_nonempty ? einst_q[head_q] : 32'h0;
    pop              = f1_valid_o & ~stall_f1_i;
  end

  // Next-state: redirect clears the queue and carries unfilled requests into drop
  always_comb begin
    pc_d      = pc_q;
    head_d    = head_q;
    tail_d    = tail_q;
    fill_d    = fill_q;
    count_d   = count_q;
    pend_d    = pend_q;
    drop_d    = drop_q;
    started_d = 1'b1;
    filled_d  = filled_q;
    epc_d     = epc_q;
    einst_d   = einst_q;
    if (redirect_valid_i) begin
      pc_d    = redirect_pc_i & ~64'h3;
      head_d  = '0;
      tail_d  = '0;
      fill_d  = '0;
      count_d = '0;
      pend_d  = '0;
      drop_d  = drop_q + pend_q - CNT_W'(resp_any);
    end else begin
      if (push) begin
        epc_d[tail_q]    = pc_q;
        filled_d[tail_q] = 1'b0;
        tail_d           = tail_q + PTR_W'(1);
        pc_d             = pc_q + 64'd4;
      end
      // Fill after allocation so a combinational memory can fill the new tail
      if (resp_any) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CNT_W'(1);
        end else begin
          einst_d[fill_q]  = imem_resp_inst_i;
          filled_d[fill_q] = 1'b1;
          fill_d           = fill_q + PTR_W'(1);
        end
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      pend_d  = pend_q + CNT_W'(push) - CNT_W'(resp_fill);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Control registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      head_q    <= '0;
      tail_q    <= '0;
      fill_q    <= '0;
      count_q   <= '0;
      pend_q    <= '0;
      drop_q    <= '0;
      started_q <= 1'b0;
      filled_q  <= '0;
    end else begin
      pc_q      <= pc_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      fill_q    <= fill_d;
      count_q   <= count_d;
      pend_q    <= pend_d;
      drop_q    <= drop_d;
      started_q <= started_d;
      filled_q  <= filled_d;
    end
  end

  // Queue payload registers
  always_ff @(posedge clk) begin
    epc_q   <= epc_d;
    einst_q <= einst_d;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: an in-order memory model with adjustable
// latency, a sequential PC expectation for the decoder side, and directed
// scenarios for streaming, stall, redirects, not-ready memory and reset.
module tb_fetch_stage;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid_i;
  logic [63:0] redirect_pc_i;
  logic        stall_f1_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [63:0] imem_req_addr_o;
  logic        imem_resp_valid_i;
  logic [31:0] imem_resp_inst_i;
  logic        f1_valid_o;
  logic [63:0] f1_pc_o;
  logic [31:0] f1_inst_o;

  fetch_stage #(.RESET_PC(RST_PC), .QDEPTH(4)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .redirect_valid_i  (redirect_valid_i),
    .redirect_pc_i     (redirect_pc_i),
    .stall_f1_i        (stall_f1_i),
    .imem_req_valid_o  (imem_req_valid_o),
    .imem_req_ready_i  (imem_req_ready_i),
    .imem_req_addr_o   (imem_req_addr_o),
    .imem_resp_valid_i (imem_resp_valid_i),
    .imem_resp_inst_i  (imem_resp_inst_i),
    .f1_valid_o        (f1_valid_o),
    .f1_pc_o           (f1_pc_o),
    .f1_inst_o         (f1_inst_o)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          cycnum = 0;
  int          lat = 1;
  int          n_dec = 0;
  int          n0;
  int          w;
  logic [63:0] exp_req;
  logic [63:0] exp_dec;
  logic [63:0] mq_addr [$];
  int          mq_due  [$];

  function automatic logic [31:0] minst(logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive memory response at the negedge, sample just
  // before the posedge, then return at the next negedge.
  task automatic cyc();
    if (rst_n && mq_addr.size() > 0 && mq_due[0] <= cycnum) begin
      imem_resp_valid_i = 1'b1;
      imem_resp_inst_i  = minst(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      imem_resp_valid_i = 1'b0;
      imem_resp_inst_i  = 32'h0;
    end
    #4;
    if (f1_valid_o && !stall_f1_i) begin
      chk("dec_pc", f1_pc_o, exp_dec);
      chk("dec_inst", {32'h0, f1_inst_o}, {32'h0, minst(exp_dec)});
      exp_dec = exp_dec + 64'd4;
      n_dec++;
    end
    if (imem_req_valid_o && imem_req_ready_i) begin
      chk("req_addr", imem_req_addr_o, exp_req);
      exp_req = exp_req + 64'd4;
      mq_addr.push_back(imem_req_addr_o);
      mq_due.push_back(cycnum + lat);
    end
    @(negedge clk);
    cycnum++;
  endtask

  task automatic idle();
    imem_req_ready_i = 1'b0;
    repeat (15) cyc();
    chk("idle_count", {61'h0, dut.count_q}, 64'd0);
    chk("idle_drop", {61'h0, dut.drop_q}, 64'd0);
  endtask

  initial begin
    rst_n             = 1'b0;
    redirect_valid_i  = 1'b0;
    redirect_pc_i     = 64'h0;
    stall_f1_i        = 1'b0;
    imem_req_ready_i  = 1'b0;
    imem_resp_valid_i = 1'b0;
    imem_resp_inst_i  = 32'h0;
    exp_req           = RST_PC;
    exp_dec           = RST_PC;
    repeat (2) @(negedge clk);
    chk("rst_f1_valid", {63'h0, f1_valid_o}, 64'd0);
    chk("rst_f1_pc", f1_pc_o, 64'd0);
    chk("rst_f1_inst", {32'h0, f1_inst_o}, 64'd0);
    chk("rst_req_valid", {63'h0, imem_req_valid_o}, 64'd0);

    // Streaming with 1-cycle memory
    rst_n = 1'b1;
    imem_req_ready_i = 1'b1;
    repeat (10) cyc();
    n0 = n_dec;
    repeat (10) cyc();
    chk("stream_rate", 64'(n_dec - n0), 64'd10);

    // Decoder backpressure
    stall_f1_i = 1'b1;
    chk("bp_valid", {63'h0, f1_valid_o}, 64'd1);
    repeat (10) begin
      cyc();
      chk("bp_hold", f1_pc_o, exp_dec);
    end
    chk("bp_full", {61'h0, dut.count_q}, 64'd4);
    chk("bp_req_valid", {63'h0, imem_req_valid_o}, 64'd0);
    stall_f1_i = 1'b0;
    n0 = n_dec;
    repeat (4) cyc();
    chk("bp_drain", 64'(n_dec - n0), 64'd4);
    idle();

    // Redirect with three requests outstanding, latency 5
    lat = 5;
    imem_req_ready_i = 1'b1;
    repeat (3) cyc();
    imem_req_ready_i = 1'b0;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 64'h0000_0000_8000_1002;
    exp_req          = 64'h0000_0000_8000_1000;
    exp_dec          = 64'h0000_0000_8000_1000;
    cyc();
    redirect_valid_i = 1'b0;
    chk("r1_drop", {61'h0, dut.drop_q}, 64'd3);
    chk("r1_addr", imem_req_addr_o, 64'h0000_0000_8000_1000);
    imem_req_ready_i = 1'b1;
    w = 0;
    while (!f1_valid_o && w < 40) begin
      cyc();
      w++;
    end
    chk("r1_first_pc", f1_pc_o, 64'h0000_0000_8000_1000);
    idle();

    // Redirect coinciding with a response, two entries unfilled
    imem_req_ready_i = 1'b1;
    repeat (2) cyc();
    imem_req_ready_i = 1'b0;
    repeat (3) cyc();
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 64'h0000_0000_8000_2000;
    exp_req          = 64'h0000_0000_8000_2000;
    exp_dec          = 64'h0000_0000_8000_2000;
    cyc();
    redirect_valid_i = 1'b0;
    chk("r2_drop", {61'h0, dut.drop_q}, 64'd1);
    lat = 1;
    imem_req_ready_i = 1'b1;
    n0 = n_dec;
    repeat (10) cyc();
    chk("r2_drop_done", {61'h0, dut.drop_q}, 64'd0);
    chk("r2_ndec", 64'(n_dec - n0), 64'd8);
    idle();

    // Back-to-back redirects, drop accumulates
    lat = 5;
    imem_req_ready_i = 1'b1;
    repeat (2) cyc();
    imem_req_ready_i = 1'b0;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 64'h0000_0000_8000_3000;
    exp_req          = 64'h0000_0000_8000_3000;
    exp_dec          = 64'h0000_0000_8000_3000;
    cyc();
    redirect_valid_i = 1'b0;
    imem_req_ready_i = 1'b1;
    cyc();
    imem_req_ready_i = 1'b0;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 64'h0000_0000_8000_4000;
    exp_req          = 64'h0000_0000_8000_4000;
    exp_dec          = 64'h0000_0000_8000_4000;
    cyc();
    redirect_valid_i = 1'b0;
    chk("r3_drop", {61'h0, dut.drop_q}, 64'd3);
    imem_req_ready_i = 1'b1;
    n0 = n_dec;
    repeat (12) cyc();
    idle();
    chk("r3_ndec", {63'h0, (n_dec > n0)}, 64'd1);

    // Memory not ready with an empty queue
    imem_req_ready_i = 1'b0;
    chk("nr_req_valid", {63'h0, imem_req_valid_o}, 64'd1);
    repeat (6) begin
      cyc();
      chk("nr_addr", imem_req_addr_o, exp_req);
      chk("nr_f1_valid", {63'h0, f1_valid_o}, 64'd0);
    end

    // Asynchronous reset in the middle of streaming
    lat = 1;
    imem_req_ready_i = 1'b1;
    repeat (8) cyc();
    chk("pre_rst_valid", {63'h0, f1_valid_o}, 64'd1);
    #2;
    rst_n = 1'b0;
    imem_resp_valid_i = 1'b0;
    #1;
    chk("arst_f1_valid", {63'h0, f1_valid_o}, 64'd0);
    chk("arst_f1_pc", f1_pc_o, 64'd0);
    chk("arst_f1_inst", {32'h0, f1_inst_o}, 64'd0);
    chk("arst_req_valid", {63'h0, imem_req_valid_o}, 64'd0);
    mq_addr.delete();
    mq_due.delete();
    @(negedge clk);
    rst_n   = 1'b1;
    exp_req = RST_PC;
    exp_dec = RST_PC;
    n0 = n_dec;
    repeat (6) cyc();
    chk("post_rst_dec", {63'h0, (n_dec > n0)}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
